memory_stage: RTL and testbench

Pipeline MEM stage between the EX/MEM register and writeback. It holds one instruction from `REG_EX_MEM`, performs at most one data-bus access (load or store), aligns and extends load data, and produces `REG_MEM_WB` for writeback. It takes part in the global stall handshake: it reports completion on `ok_to_proceed` and latches its output only when `ok_to_proceed_overall` is high.

---
 rtl/memory_stage_pkg.sv | 67 ++++++
 rtl/memory_stage_align.sv | 46 ++++
 rtl/memory_stage.sv | 119 +++++++++++
 tb/tb_memory_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared types for the MEM stage: pipeline register structs, FSM state enum,
// load/store size encodings and the alignment helper.
package common;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_D  = 3'b011;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;
  localparam logic [2:0] MEM_WU = 3'b110;

  typedef struct packed {
    logic        valid;
    logic        isWriteBack;
    logic        isMemRead;
    logic        isMemWrite;
    logic        isJump;
    logic        isMem;
    logic [2:0]  memSize;
    logic [63:0] aluOut;
    logic [63:0] memWriteData;
    logic [63:0] pcPlus4;
    logic [4:0]  wd;
    logic [63:0] instrAddr;
    logic [31:0] instr;
    logic        isCSRWrite;
    logic [11:0] CSR_addr;
    logic [63:0] CSR_write_value;
  } REG_EX_MEM;

  typedef struct packed {
    logic        valid;
    logic        isWriteBack;
    logic        isMemRead;
    logic        isJump;
    logic        isMem;
    logic [63:0] aluOut;
    logic [63:0] pcPlus4;
    logic [4:0]  wd;
    logic [63:0] instrAddr;
    logic [31:0] instr;
    logic        isCSRWrite;
    logic [11:0] CSR_addr;
    logic [63:0] CSR_write_value;
    logic [63:0] memAddr;
    logic [63:0] memOut;
    logic        memMisalign;
  } REG_MEM_WB;

  // Size taken from funct3[1:0], so signed and unsigned variants share a rule.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [2:0] addr);
    case (size[1:0])
      2'd0:    return 1'b0;
      2'd1:    return addr[0];
      2'd2:    return |addr[1:0];
      default: return |addr;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_align.sv
// Combinational lane logic: load extraction/extension and store data/strobe shift.
module mem_align
  import common::*;
(
  input  logic [2:0]  size,
  input  logic [2:0]  addr,
  input  logic [63:0] wdata,
  input  logic [63:0] rdata,
  output logic [63:0] load_data,
  output logic [63:0] store_data,
  output logic [7:0]  store_strobe
);

  logic [5:0]  lane;
  logic [63:0] shifted;
  logic [7:0]  base;

  assign lane    = {addr, 3'b000};
  assign shifted = rdata >> lane;

  always_comb begin
    base      = 8'h01;
    load_data = shifted;
    case (size[1:0])
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      2'd3:    base = 8'hFF;
      default: base = 8'h01;
    endcase
    case (size)
      MEM_B:   load_data = {{56{shifted[7]}}, shifted[7:0]};
      MEM_H:   load_data = {{48{shifted[15]}}, shifted[15:0]};
      MEM_W:   load_data = {{32{shifted[31]}}, shifted[31:0]};
      MEM_D:   load_data = shifted;
      MEM_BU:  load_data = {56'd0, shifted[7:0]};
      MEM_HU:  load_data = {48'd0, shifted[15:0]};
      MEM_WU:  load_data = {32'd0, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  assign store_data   = wdata << lane;
  // 8-bit shift: bytes that would spill past the doubleword are dropped.
  assign store_strobe = base << addr;

endmodule

// File: rtl/memory_stage.sv
// Pipeline MEM stage: one data-bus access per instruction, load alignment, MEM/WB register.
// Optional misaligned-access trap when MEM_MISALIGN_TRAP_EN is defined.
module memory_stage
  import common::*;
(
  input  logic        clk,
  input  logic        rst,
  input  REG_EX_MEM   moduleIn,
  output REG_MEM_WB   moduleOut,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic        dreq_write,
  output logic [7:0]  dreq_strobe,
  output logic [63:0] dreq_data,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        ok_to_proceed,
  input  logic        ok_to_proceed_overall,
  output mem_state_t  dbg_state
);

  // Handshake: dreq_valid rises on IDLE->BUSY and holds with all request
  // fields constant until dresp_data_ok is seen in BUSY; data_ok in any other
  // state is ignored. The stage advances only when ok_to_proceed_overall is 1.

  mem_state_t  state, state_next;
  logic        mem_pending, misalign, start_access;
  logic        misalign_q;
  logic [63:0] mem_data;
  logic [63:0] load_data, store_data;
  logic [7:0]  store_strobe;

  assign mem_pending = moduleIn.valid & moduleIn.isMem;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = is_misaligned(moduleIn.memSize, moduleIn.aluOut[2:0]);
`else
  assign misalign = 1'b0;
`endif

  assign start_access  = (state == IDLE) & mem_pending & ~misalign;
  assign ok_to_proceed = (state == DONE) | ~mem_pending;
  assign dbg_state     = state;

  mem_align u_align (
    .size         (moduleIn.memSize),
    .addr         (moduleIn.aluOut[2:0]),
    .wdata        (moduleIn.memWriteData),
    .rdata        (dresp_data),
    .load_data    (load_data),
    .store_data   (store_data),
    .store_strobe (store_strobe)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_pending) state_next = misalign ? DONE : BUSY;
      BUSY:    if (dresp_data_ok) state_next = DONE;
      DONE:    if (ok_to_proceed_overall) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dreq_valid  <= 1'b0;
      dreq_addr   <= '0;
      dreq_write  <= 1'b0;
      dreq_strobe <= '0;
      dreq_data   <= '0;
      mem_data    <= '0;
      misalign_q  <= 1'b0;
      moduleOut   <= '0;
    end else begin
      if (start_access) begin
        dreq_valid  <= 1'b1;
        dreq_addr   <= moduleIn.aluOut;
        dreq_write  <= moduleIn.isMemWrite;
        dreq_strobe <= moduleIn.isMemWrite ? store_strobe : 8'h00;
        dreq_data   <= store_data;
      end
      if ((state == IDLE) && mem_pending && misalign) misalign_q <= 1'b1;
      if ((state == BUSY) && dresp_data_ok) begin
        dreq_valid <= 1'b0;
        mem_data   <= moduleIn.isMemRead ? load_data : 64'd0;
      end
      if (ok_to_proceed_overall) begin
        moduleOut.valid           <= moduleIn.valid;
        moduleOut.isWriteBack     <= moduleIn.isWriteBack & ~misalign_q;
        moduleOut.isMemRead       <= moduleIn.isMemRead;
        moduleOut.isJump          <= moduleIn.isJump;
        moduleOut.isMem           <= moduleIn.isMem;
        moduleOut.aluOut          <= moduleIn.aluOut;
        moduleOut.pcPlus4         <= moduleIn.pcPlus4;
        moduleOut.wd              <= moduleIn.wd;
        moduleOut.instrAddr       <= moduleIn.instrAddr;
        moduleOut.instr           <= moduleIn.instr;
        moduleOut.isCSRWrite      <= moduleIn.isCSRWrite;
        moduleOut.CSR_addr        <= moduleIn.CSR_addr;
        moduleOut.CSR_write_value <= moduleIn.CSR_write_value;
        moduleOut.memAddr         <= moduleIn.aluOut;
        moduleOut.memOut          <= (moduleIn.isMem & moduleIn.isMemRead) ? mem_data : 64'd0;
        moduleOut.memMisalign     <= misalign_q;
        // Captured state belongs to the instruction leaving now.
        mem_data   <= '0;
        misalign_q <= 1'b0;
      end else begin
        moduleOut.valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a memOut/pass-through scoreboard.
module tb_memory_stage;
  import common::*;

  logic        clk = 1'b0;
  logic        rst;
  REG_EX_MEM   min;
  REG_MEM_WB   mout;
  logic        dreq_valid, dreq_write, dresp_data_ok, ok_to_proceed;
  logic [63:0] dreq_addr, dreq_data, dresp_data;
  logic [7:0]  dreq_strobe;
  logic        stall_other, overall;
  mem_state_t  dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic [65:0] exp_aux_q[$];  // {memMisalign, isWriteBack, aluOut}

  assign overall = ok_to_proceed & ~stall_other;

  memory_stage dut (
    .clk                   (clk),
    .rst                   (rst),
    .moduleIn              (min),
    .moduleOut             (mout),
    .dreq_valid            (dreq_valid),
    .dreq_addr             (dreq_addr),
    .dreq_write            (dreq_write),
    .dreq_strobe           (dreq_strobe),
    .dreq_data             (dreq_data),
    .dresp_data_ok         (dresp_data_ok),
    .dresp_data            (dresp_data),
    .ok_to_proceed         (ok_to_proceed),
    .ok_to_proceed_overall (overall),
    .dbg_state             (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic REG_EX_MEM mk(input logic mem, input logic rd, input logic wr,
                                   input logic [2:0] size, input logic [63:0] addr,
                                   input logic [63:0] wdata);
    REG_EX_MEM r;
    r              = '0;
    r.valid        = 1'b1;
    r.isMem        = mem;
    r.isMemRead    = rd;
    r.isMemWrite   = wr;
    r.memSize      = size;
    r.aluOut       = addr;
    r.memWriteData = wdata;
    r.isWriteBack  = ~wr;
    r.pcPlus4      = addr ^ 64'h4;
    r.wd           = 5'd7;
    r.instr        = 32'h0000_0013;
    return r;
  endfunction

  task automatic sb_push(input logic [63:0] mem, input logic wb, input logic mis, input logic [63:0] alu);
    exp_q.push_back(mem);
    exp_aux_q.push_back({mis, wb, alu});
  endtask

  task automatic sb_check();
    logic [63:0] e;
    logic [65:0] a;
    check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      a = exp_aux_q.pop_front();
      check("out_valid", mout.valid, 1);
      check("memOut", mout.memOut, e);
      check("aluOut", mout.aluOut, a[63:0]);
      check("memAddr", mout.memAddr, a[63:0]);
      check("isWriteBack", mout.isWriteBack, a[64]);
      check("memMisalign", mout.memMisalign, a[65]);
    end
  endtask

  // Drives one memory op from IDLE through advance; inputs change at negedge.
  task automatic run_mem(input REG_EX_MEM ins, input int lat, input logic [63:0] rdata,
                         input logic [63:0] exp_mem, input logic [7:0] exp_strb,
                         input logic [63:0] exp_wd, input int hold);
    min         = ins;
    stall_other = (hold > 0);
    sb_push(exp_mem, ins.isWriteBack, 1'b0, ins.aluOut);
    #1 check("otp_pending", ok_to_proceed, 0);
    @(negedge clk);
    check("state_busy", dbg_state, BUSY);
    check("dreq_valid_busy", dreq_valid, 1);
    check("dreq_addr", dreq_addr, ins.aluOut);
    check("dreq_write", dreq_write, ins.isMemWrite);
    check("dreq_strobe", dreq_strobe, exp_strb);
    check("dreq_data", dreq_data, exp_wd);
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check("busy_wait_valid", dreq_valid, 1);
      check("busy_wait_otp", ok_to_proceed, 0);
    end
    dresp_data_ok = 1'b1;
    dresp_data    = rdata;
    @(negedge clk);
    dresp_data_ok = 1'b0;
    dresp_data    = {$urandom, $urandom};
    check("state_done", dbg_state, DONE);
    check("dreq_valid_done", dreq_valid, 0);
    check("otp_done", ok_to_proceed, 1);
    for (int i = 0; i < hold; i++) begin
      dresp_data_ok = (i == 0);  // stray response outside BUSY
      @(negedge clk);
      dresp_data_ok = 1'b0;
      check("hold_bubble", mout.valid, 0);
      check("hold_state", dbg_state, DONE);
      check("hold_dreq", dreq_valid, 0);
    end
    stall_other = 1'b0;
    @(negedge clk);
    min.valid = 1'b0;
    check("state_idle_after", dbg_state, IDLE);
    check("dreq_after", dreq_valid, 0);
    sb_check();
    @(negedge clk);
    check("bubble_after", mout.valid, 0);
  endtask

  initial begin
    logic [63:0] rnd;
    int          lat;
    rst           = 1'b1;
    min           = '0;
    dresp_data_ok = 1'b0;
    dresp_data    = '0;
    stall_other   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", dbg_state, IDLE);
    check("reset_dreq", dreq_valid, 0);
    check("reset_out_valid", mout.valid, 0);
    check("reset_memOut", mout.memOut, 0);
    rst = 1'b0;

    // Non-memory instruction passes straight through.
    min = mk(1'b0, 1'b0, 1'b0, MEM_B, 64'h1234, 64'd0);
    sb_push(64'd0, 1'b1, 1'b0, 64'h1234);
    #1 check("add_otp", ok_to_proceed, 1);
    check("add_dreq", dreq_valid, 0);
    @(negedge clk);
    sb_check();
    check("add_dreq_after", dreq_valid, 0);
    min.valid = 1'b0;
    @(negedge clk);

    run_mem(mk(1, 1, 0, MEM_B,  64'h1003, 0), 2, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 8'h00, 64'd0, 0);
    run_mem(mk(1, 1, 0, MEM_BU, 64'h1003, 0), 2, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080, 8'h00, 64'd0, 0);
    run_mem(mk(1, 0, 1, MEM_H,  64'h2006, 64'hABCD), 0, 64'd0, 64'd0, 8'hC0, 64'hABCD_0000_0000_0000, 0);
    run_mem(mk(1, 1, 0, MEM_W,  64'h1004, 0), 1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000, 8'h00, 64'd0, 0);
    run_mem(mk(1, 1, 0, MEM_HU, 64'h0002, 0), 0, 64'h0000_1234_5678_9ABC, 64'h0000_0000_0000_5678, 8'h00, 64'd0, 0);
    run_mem(mk(1, 1, 0, MEM_WU, 64'h1004, 0), 3, 64'hDEAD_BEEF_0000_0000, 64'h0000_0000_DEAD_BEEF, 8'h00, 64'd0, 0);

    rnd = {$urandom, $urandom};
    lat = $urandom_range(0, 3);
    run_mem(mk(1, 1, 0, MEM_D, 64'h3000, 0), lat, rnd, rnd, 8'h00, 64'd0, 5);
    rnd = {$urandom, $urandom};
    run_mem(mk(1, 0, 1, MEM_D, 64'h0008, rnd), $urandom_range(0, 2), 64'd0, 64'd0, 8'hFF, rnd, 0);

`ifdef MEM_MISALIGN_TRAP_EN
    min = mk(1, 1, 0, MEM_W, 64'h1002, 0);
    sb_push(64'd0, 1'b0, 1'b1, 64'h1002);
    #1 check("mis_otp_pending", ok_to_proceed, 0);
    @(negedge clk);
    check("mis_state_done", dbg_state, DONE);
    check("mis_no_dreq", dreq_valid, 0);
    @(negedge clk);
    min.valid = 1'b0;
    check("mis_no_dreq_after", dreq_valid, 0);
    sb_check();
    @(negedge clk);
`else
    run_mem(mk(1, 0, 1, MEM_D, 64'h0004, 64'h1122_3344_5566_7788), 1, 64'd0, 64'd0, 8'hF0, 64'h5566_7788_0000_0000, 0);
    run_mem(mk(1, 1, 0, MEM_W, 64'h1002, 0), 0, 64'h0000_0000_FFFF_0000, 64'h0000_0000_0000_FFFF, 8'h00, 64'd0, 0);
`endif

    // Reset while the access is outstanding.
    min = mk(1, 1, 0, MEM_W, 64'h0010, 0);
    @(negedge clk);
    check("rst_pre_busy", dbg_state, BUSY);
    check("rst_pre_dreq", dreq_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_dreq", dreq_valid, 0);
    check("rst_state", dbg_state, IDLE);
    check("rst_out_valid", mout.valid, 0);
    rst       = 1'b0;
    min.valid = 1'b0;
    @(negedge clk);
    check("rst_idle_hold", dbg_state, IDLE);
    check("rst_no_dreq", dreq_valid, 0);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
